sobel_param_obf: RTL and testbench
==================================

# sobel_param_obf

Parametrised, key-locked Sobel edge-detection engine for whole frames. It succeeds the fixed 512x512, 8-bit Sobel block and adds the following:
- generic image size and pixel width;
- internal constant kernels;
- a border fill value;
- a threshold output mode;
- a multi-bit XOR-mask lock.

It sits between an input frame RAM and an output frame RAM and keeps the ap_start/ap_done/ap_idle/ap_ready block-level handshake.

## Interface
- IMG_W, 512: frame width in pixels. Must be at least 3.
- IMG_H, 512: frame height in pixels. Must be at least 3.
- PIX_W, 8: pixel width in bits.
- KEY_W, 8: key width. Must satisfy 1 ≤ KEY_W ≤ PIX_W.
- KEY, 8'hA5: correct unlock key.
- BORDER_VAL, all-ones: value written to every border pixel.
- Derived widths (not parameters): XW = clog2(IMG_W), YW = clog2(IMG_H), AW = XW + YW.
- ap_clk  in  1  sole clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  request to process one frame.
- ap_done  out  1  one-cycle pulse at frame end.
- ap_idle  out  1  high when in IDLE and ap_start is low.
- ap_ready  out  1  identical to ap_done.
- mode  in  1  0 = compat magnitude, 1 = threshold. Sampled at start.
- threshold  in  PIX_W+3  threshold-mode limit, unsigned. Sampled at start.
- working_key  in  KEY_W  unlock key. Sampled at start.
- indata_address0  out  AW  read address {y, x}.
- indata_ce0  out  1  read enable.
- indata_q0  in  PIX_W  read data, valid one cycle after ce0.
- outdata_address0  out  AW  write address {y, x}.
- outdata_ce0  out  1  write enable.
- outdata_we0  out  1  write strobe.
- outdata_d0  out  PIX_W  write data.

## Operation
- States: IDLE, ROW, COL, TADDR, TDATA, TACC, CALC, WRITE. The FSM is one-hot.
- IDLE:
  - On ap_start=1: y←0, sample mode/threshold/working_key → ROW.
- ROW:
  - If y==IMG_H: assert ap_done=ap_ready=1 → IDLE.
  - Else: x←0, clear accumulators → COL.
- COL:
  - If x==IMG_W: y←y+1 → ROW.
  - Else if x or y is on the border (0 or last): result←BORDER_VAL → WRITE.
  - Else: tap←0, gx←gy←0 → TADDR.
- TADDR:
  - indata_ce0=1.
  - address = {y+dy, x+dx}, where dy=tap/3−1 and dx=tap%3−1, taps in row-major order.
- TDATA: register indata_q0.
- TACC:
  - gx += KX[tap]·p and gy += KY[tap]·p.
  - KX = [-1 0 1; -2 0 2; -1 0 1], KY = [-1 -2 -1; 0 0 0; 1 2 1].
  - tap++. If tap was 8 → CALC, else → TADDR.
  - Zero-coefficient taps are still read, so interior timing is fixed.
- CALC:
  - Mode 0: cx = clamp(gx, 0, 2^PIX_W−1), likewise cy. result = ~((cx+cy) mod 2^PIX_W).
  - Mode 1: result = (|gx|+|gy| ≥ threshold) ? all-ones : 0.
  - → WRITE.
- WRITE:
  - outdata_ce0=outdata_we0=1, address {y,x}.
  - d0 = result ^ mask, where mask = (working_key ^ KEY) zero-extended to PIX_W.
  - x++ → COL.
- Arithmetic:
  - gx and gy are signed, PIX_W+4 bits; no overflow is possible.
  - |gx|+|gy| is unsigned, PIX_W+3 bits.
  - Pixels are unsigned.
- The correct key gives mask 0 and the true image. Any wrong key corrupts every written pixel, borders included.
- ap_start while not in IDLE is ignored. Changes to mode, threshold and key mid-frame have no effect.
- A new frame may start in the IDLE cycle right after ap_done.

## Timing
- Reset (asynchronous assert): FSM→IDLE, x=y=tap=0, accumulators=0, sampled registers=0.
  - All outputs 0 except ap_idle, which is 1 when ap_start=0.
- Reset asserted mid-frame aborts the frame immediately. No further RAM access and no ap_done.
- Cycle 0 is the IDLE cycle with ap_start=1; ROW is entered at cycle 1.
- Border pixel: 2 cycles (COL, WRITE).
- Interior pixel: 30 cycles (COL + 9×3 tap cycles + CALC + WRITE).
- Each row adds 1 ROW cycle and 1 terminating COL cycle.
- ap_done asserts at cycle 1 + H + H(W+1) + W·H + 28(W−2)(H−2).
  - For 4×4 this is cycle 153.
- Read data is captured exactly one cycle after indata_ce0.
- One write per pixel, in raster order. outdata_ce0 and indata_ce0 are never high in the same cycle.

## Test plan
- Ramp, correct key: 4×4, PIX_W=8, pixel=10·x, KEY=working_key=8'hA5, mode 0.
  - Interior pixels (1,1),(2,1),(1,2),(2,2) = 175.
  - Borders = 255.
  - ap_done at cycle 153, exactly 16 writes.
- Threshold mode: same ramp, mode 1.
  - threshold=80 → interior 255.
  - threshold=81 → interior 0.
  - Borders 255 in both cases.
- Saturation: 4×4, pixel = (x<2 ? 0 : 255).
  - Mode 0: interior 0.
  - Mirrored image (x<2 ? 255 : 0), which gives gx=−1020: interior 255.
  - Mode 1 with threshold=1020: interior 255 for both images.
- Wrong key: ramp, working_key=8'hA4.
  - Interior 174, borders 254.
  - Key 8'h5A: interior 175^8'hFF=80.
- Handshake:
  - ap_idle=1 in IDLE with ap_start low.
  - ap_start pulses mid-frame are ignored.
  - Back-to-back start in the cycle after ap_done begins a new frame.
  - Changing the key mid-frame does not alter output.
- Reset mid-frame: assert ap_rst_n=0 during TDATA of pixel (1,1).
  - All outputs drop immediately; no write is issued; ap_done is never seen.
  - The following frame completes with correct data.

Source files
------------

// File: rtl/sobel_param_obf.sv
`default_nettype none
// ============================================================================
// Module   : sobel_param_obf
// Brief    : Key-locked whole-frame Sobel engine between input and output
//            frame RAMs, with magnitude or threshold output.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_param_obf #(
    parameter int                IMG_W      = 512,
    parameter int                IMG_H      = 512,
    parameter int                PIX_W      = 8,
    parameter int                KEY_W      = 8,
    parameter logic [KEY_W-1:0]  KEY        = 8'hA5,
    parameter logic [PIX_W-1:0]  BORDER_VAL = '1
) (
    input  logic                                     ap_clk,
    input  logic                                     ap_rst_n,
    input  logic                                     ap_start,
    output logic                                     ap_done,
    output logic                                     ap_idle,
    output logic                                     ap_ready,
    input  logic                                     mode,
    input  logic [PIX_W+2:0]                         threshold,
    input  logic [KEY_W-1:0]                         working_key,
    output logic [$clog2(IMG_W)+$clog2(IMG_H)-1:0]   indata_address0,
    output logic                                     indata_ce0,
    input  logic [PIX_W-1:0]                         indata_q0,
    output logic [$clog2(IMG_W)+$clog2(IMG_H)-1:0]   outdata_address0,
    output logic                                     outdata_ce0,
    output logic                                     outdata_we0,
    output logic [PIX_W-1:0]                         outdata_d0
);

    localparam int c_XW = $clog2(IMG_W);
    localparam int c_YW = $clog2(IMG_H);
    localparam int c_AW = c_XW + c_YW;
    localparam int c_GW = PIX_W + 4;

    localparam logic [7:0] c_ST_IDLE  = 8'b0000_0001;
    localparam logic [7:0] c_ST_ROW   = 8'b0000_0010;
    localparam logic [7:0] c_ST_COL   = 8'b0000_0100;
    localparam logic [7:0] c_ST_TADDR = 8'b0000_1000;
    localparam logic [7:0] c_ST_TDATA = 8'b0001_0000;
    localparam logic [7:0] c_ST_TACC  = 8'b0010_0000;
    localparam logic [7:0] c_ST_CALC  = 8'b0100_0000;
    localparam logic [7:0] c_ST_WRITE = 8'b1000_0000;

    // Counters carry one extra bit so they can reach IMG_W / IMG_H.
    localparam logic [c_XW:0] c_X_END  = (c_XW+1)'(IMG_W);
    localparam logic [c_XW:0] c_X_LAST = (c_XW+1)'(IMG_W - 1);
    localparam logic [c_XW:0] c_X_ONE  = (c_XW+1)'(1);
    localparam logic [c_YW:0] c_Y_END  = (c_YW+1)'(IMG_H);
    localparam logic [c_YW:0] c_Y_LAST = (c_YW+1)'(IMG_H - 1);
    localparam logic [c_YW:0] c_Y_ONE  = (c_YW+1)'(1);

    logic [7:0]               r_state, w_next;
    logic [c_XW:0]            r_x;
    logic [c_YW:0]            r_y;
    logic [3:0]               r_tap;
    logic signed [c_GW-1:0]   r_gx, r_gy;
    logic [PIX_W-1:0]         r_pix, r_result;
    logic                     r_mode;
    logic [PIX_W+2:0]         r_thr;
    logic [KEY_W-1:0]         r_key;

    logic [1:0]               w_dr, w_dc;
    logic [2:0]               w_kx, w_ky;
    logic [c_XW-1:0]          w_tx;
    logic [c_YW-1:0]          w_ty;
    logic signed [c_GW-1:0]   w_px;
    logic [PIX_W+2:0]         w_ax, w_ay, w_mag;
    logic [PIX_W-1:0]         w_sum, w_calc, w_mask;
    logic                     w_border;

    function automatic logic signed [c_GW-1:0] scale(input logic [2:0] c,
                                                     input logic signed [c_GW-1:0] p);
        case (c)
            3'b001:  scale = p;
            3'b010:  scale = p <<< 1;
            3'b111:  scale = -p;
            3'b110:  scale = -(p <<< 1);
            default: scale = '0;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] clamp(input logic signed [c_GW-1:0] g);
        if (g[c_GW-1])
            clamp = '0;
        else if (|g[c_GW-2:PIX_W])
            clamp = '1;
        else
            clamp = g[PIX_W-1:0];
    endfunction

    // Tap table: row/column offset (+1 biased) and KX/KY coefficients.
    always_comb begin
        w_dr = 2'd0;
        w_dc = 2'd0;
        w_kx = 3'b000;
        w_ky = 3'b000;
        case (r_tap)
            4'd0:    begin w_dr = 2'd0; w_dc = 2'd0; w_kx = 3'b111; w_ky = 3'b111; end
            4'd1:    begin w_dr = 2'd0; w_dc = 2'd1; w_kx = 3'b000; w_ky = 3'b110; end
            4'd2:    begin w_dr = 2'd0; w_dc = 2'd2; w_kx = 3'b001; w_ky = 3'b111; end
            4'd3:    begin w_dr = 2'd1; w_dc = 2'd0; w_kx = 3'b110; w_ky = 3'b000; end
            4'd4:    begin w_dr = 2'd1; w_dc = 2'd1; w_kx = 3'b000; w_ky = 3'b000; end
            4'd5:    begin w_dr = 2'd1; w_dc = 2'd2; w_kx = 3'b010; w_ky = 3'b000; end
            4'd6:    begin w_dr = 2'd2; w_dc = 2'd0; w_kx = 3'b111; w_ky = 3'b001; end
            4'd7:    begin w_dr = 2'd2; w_dc = 2'd1; w_kx = 3'b000; w_ky = 3'b010; end
            default: begin w_dr = 2'd2; w_dc = 2'd2; w_kx = 3'b001; w_ky = 3'b001; end
        endcase
    end

    assign w_tx     = r_x[c_XW-1:0] + c_XW'(w_dc) - c_XW'(1);
    assign w_ty     = r_y[c_YW-1:0] + c_YW'(w_dr) - c_YW'(1);
    assign w_px     = $signed({4'b0000, r_pix});
    assign w_ax     = r_gx[c_GW-1] ? (PIX_W+3)'(-r_gx) : r_gx[PIX_W+2:0];
    assign w_ay     = r_gy[c_GW-1] ? (PIX_W+3)'(-r_gy) : r_gy[PIX_W+2:0];
    assign w_mag    = w_ax + w_ay;
    assign w_sum    = clamp(r_gx) + clamp(r_gy);
    assign w_calc   = r_mode ? ((w_mag >= r_thr) ? '1 : '0) : ~w_sum;
    assign w_border = (r_x == '0) || (r_x == c_X_LAST) || (r_y == '0) || (r_y == c_Y_LAST);

    always_comb begin
        w_mask = '0;
        w_mask[KEY_W-1:0] = r_key ^ KEY;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        ap_done          = 1'b0;
        indata_ce0       = 1'b0;
        indata_address0  = '0;
        outdata_ce0      = 1'b0;
        outdata_we0      = 1'b0;
        outdata_address0 = '0;
        outdata_d0       = '0;
        case (r_state)
            c_ST_IDLE:  if (ap_start) w_next = c_ST_ROW;
            c_ST_ROW: begin
                if (r_y == c_Y_END) begin
                    ap_done = 1'b1;
                    w_next  = c_ST_IDLE;
                end else begin
                    w_next  = c_ST_COL;
                end
            end
            c_ST_COL: begin
                if (r_x == c_X_END)
                    w_next = c_ST_ROW;
                else if (w_border)
                    w_next = c_ST_WRITE;
                else
                    w_next = c_ST_TADDR;
            end
            c_ST_TADDR: begin
                indata_ce0      = 1'b1;
                indata_address0 = {w_ty, w_tx};
                w_next          = c_ST_TDATA;
            end
            c_ST_TDATA: w_next = c_ST_TACC;
            c_ST_TACC:  w_next = (r_tap == 4'd8) ? c_ST_CALC : c_ST_TADDR;
            c_ST_CALC:  w_next = c_ST_WRITE;
            c_ST_WRITE: begin
                outdata_ce0      = 1'b1;
                outdata_we0      = 1'b1;
                outdata_address0 = {r_y[c_YW-1:0], r_x[c_XW-1:0]};
                outdata_d0       = r_result ^ w_mask;
                w_next           = c_ST_COL;
            end
            default:    w_next = c_ST_IDLE;
        endcase
    end

    assign ap_ready = ap_done;
    assign ap_idle  = (r_state == c_ST_IDLE) && !ap_start;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_tap    <= '0;
            r_gx     <= '0;
            r_gy     <= '0;
            r_pix    <= '0;
            r_result <= '0;
            r_mode   <= 1'b0;
            r_thr    <= '0;
            r_key    <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (ap_start) begin
                        r_y    <= '0;
                        r_mode <= mode;
                        r_thr  <= threshold;
                        r_key  <= working_key;
                    end
                end
                c_ST_ROW: begin
                    if (r_y != c_Y_END) begin
                        r_x  <= '0;
                        r_gx <= '0;
                        r_gy <= '0;
                    end
                end
                c_ST_COL: begin
                    if (r_x == c_X_END) begin
                        r_y <= r_y + c_Y_ONE;
                    end else if (w_border) begin
                        r_result <= BORDER_VAL;
                    end else begin
                        r_tap <= '0;
                        r_gx  <= '0;
                        r_gy  <= '0;
                    end
                end
                c_ST_TDATA: r_pix <= indata_q0;
                c_ST_TACC: begin
                    r_gx  <= r_gx + scale(w_kx, w_px);
                    r_gy  <= r_gy + scale(w_ky, w_px);
                    r_tap <= r_tap + 4'd1;
                end
                c_ST_CALC:  r_result <= w_calc;
                c_ST_WRITE: r_x <= r_x + c_X_ONE;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_param_obf.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_param_obf
// Brief    : Scoreboard bench for sobel_param_obf on a 4x4, 8-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_param_obf;

    localparam int W = 4;
    localparam int H = 4;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready;
    logic        mode;
    logic [10:0] threshold;
    logic [7:0]  working_key;
    logic [3:0]  indata_address0, outdata_address0;
    logic        indata_ce0, outdata_ce0, outdata_we0;
    logic [7:0]  indata_q0, outdata_d0;

    logic [7:0]  mem [W*H];

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_writes = 0;

    sobel_param_obf #(
        .IMG_W(W), .IMG_H(H), .PIX_W(8), .KEY_W(8), .KEY(8'hA5), .BORDER_VAL(8'hFF)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .mode(mode), .threshold(threshold), .working_key(working_key),
        .indata_address0(indata_address0), .indata_ce0(indata_ce0), .indata_q0(indata_q0),
        .outdata_address0(outdata_address0), .outdata_ce0(outdata_ce0),
        .outdata_we0(outdata_we0), .outdata_d0(outdata_d0)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk)
        if (indata_ce0) indata_q0 <= mem[indata_address0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every RAM write.
    always @(negedge ap_clk) begin
        if (indata_ce0 || outdata_ce0) begin
            n_checks++;
            if (indata_ce0 && outdata_ce0) begin
                n_fail++;
                $display("FAIL ce_overlap: indata_ce0 and outdata_ce0 both 1, expected exclusive");
            end
        end
        if (outdata_ce0 && outdata_we0) begin
            n_writes++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                         outdata_address0, outdata_d0);
            end else begin
                mon_e = sb.pop_front();
                chk("wr_addr", 32'(outdata_address0), 32'(mon_e.addr));
                chk("wr_data", 32'(outdata_d0), 32'(mon_e.data));
            end
        end
    end

    // img: 0 = ramp 10*x, 1 = step (x<2 ? 0 : 255), 2 = mirrored step
    task automatic load(input int img);
        for (int i = 0; i < W*H; i++) begin
            int x;
            x = i % W;
            case (img)
                0:       mem[i] = 8'(10 * x);
                1:       mem[i] = (x < 2) ? 8'd0 : 8'd255;
                default: mem[i] = (x < 2) ? 8'd255 : 8'd0;
            endcase
        end
    endtask

    task automatic push_exp(input int vint, input int vbord, input int npix);
        for (int i = 0; i < npix; i++) begin
            int x, y;
            exp_t e;
            x = i % W;
            y = i / W;
            e.addr = 4'(i);
            e.data = (x == 0 || y == 0 || x == W-1 || y == H-1) ? 8'(vbord) : 8'(vint);
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input int img, input logic md, input int thr, input logic [7:0] key,
                             input int vint, input int vbord, input bit chained,
                             input bit disturb, input bit chain_next);
        int cyc;
        int w0;
        bit seen;
        load(img);
        mode        = md;
        threshold   = 11'(thr);
        working_key = key;
        push_exp(vint, vbord, W*H);
        @(negedge ap_clk);
        if (!chained) begin
            chk("idle_high", 32'(ap_idle), 32'd1);
            ap_start = 1'b1;
        end
        w0   = n_writes;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge ap_clk);
            cyc++;
            if (cyc == 1) ap_start = 1'b0;
            if (disturb) begin
                if (cyc == 40) begin
                    working_key = ~key;
                    mode        = ~md;
                    threshold   = '0;
                end
                if (cyc == 50) ap_start = 1'b1;
                if (cyc == 51) ap_start = 1'b0;
            end
            if (ap_done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("done_cycle", 32'(cyc), 32'd153);
        chk("ready_eq_done", 32'(ap_ready), 32'd1);
        chk("write_count", 32'(n_writes - w0), 32'(W*H));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        working_key = key;
        mode        = md;
        threshold   = 11'(thr);
        if (chain_next) ap_start = 1'b1;
    endtask

    initial begin
        int  dones;
        int  w0;
        bit  got;
        mode        = 1'b0;
        threshold   = '0;
        working_key = 8'hA5;
        load(0);
        repeat (2) @(negedge ap_clk);
        chk("rst_outputs", 32'({ap_done, ap_ready, indata_ce0, outdata_ce0, outdata_we0,
                                indata_address0, outdata_address0, outdata_d0}), 32'd0);
        chk("rst_idle", 32'(ap_idle), 32'd1);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("idle_after_rst", 32'(ap_idle), 32'd1);

        //        img md  thr   key    int  bord chn dst nxt
        run_frame(0,  0,  0,    8'hA5, 175, 255, 0,  1,  0);
        run_frame(0,  1,  80,   8'hA5, 255, 255, 0,  0,  1);
        run_frame(0,  1,  81,   8'hA5, 0,   255, 1,  0,  0);
        run_frame(1,  0,  0,    8'hA5, 0,   255, 0,  0,  0);
        run_frame(2,  0,  0,    8'hA5, 255, 255, 0,  0,  0);
        run_frame(1,  1,  1020, 8'hA5, 255, 255, 0,  0,  0);
        run_frame(2,  1,  1020, 8'hA5, 255, 255, 0,  0,  0);
        run_frame(0,  0,  0,    8'hA4, 174, 254, 0,  0,  0);
        run_frame(0,  0,  0,    8'h5A, 80,  0,   0,  0,  0);

        // Abort a frame with reset during TDATA of pixel (1,1).
        load(0);
        mode        = 1'b0;
        threshold   = '0;
        working_key = 8'hA5;
        push_exp(175, 255, W + 1);
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge ap_clk);
            if (indata_ce0) got = 1'b1;
        end
        chk("first_tap_seen", 32'(got), 32'd1);
        chk("first_tap_addr", 32'(indata_address0), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({ap_done, ap_ready, indata_ce0, outdata_ce0, outdata_we0,
                                  indata_address0, outdata_address0, outdata_d0}), 32'd0);
        chk("abort_idle", 32'(ap_idle), 32'd1);
        chk("abort_writes_done", 32'(sb.size()), 32'd0);
        w0    = n_writes;
        dones = 0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            if (ap_done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        chk("abort_no_write", 32'(n_writes - w0), 32'd0);
        run_frame(0, 0, 0, 8'hA5, 175, 255, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
